// File: rtl/recv_pkg.sv
// Shared state encoding and line levels for the paired-line serial receiver.
package recv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/lane_deser.sv
// One lane of the deserialiser: writes the sampled line into bit[idx] on load,
// clears the whole word at the start of a frame.
module lane_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] idx,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] word_reg;
    logic [WIDTH-1:0] word_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign word_next[gi] = clear                                   ? 1'b0   :
                                   (load && (idx == CNT_W'(gi)))           ? bit_in :
                                                                             word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_reg <= '0;
        end else begin
            word_reg <= word_next;
        end
    end

    assign word = word_reg;

endmodule

// File: rtl/receive_pair.sv
// Paired-line serial receiver: start detect on the top line, lockstep capture of
// both lanes, stop-bit check, and a one-entry valid/ready holding buffer.
module receive_pair
    import recv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_top_in,
    input  logic             data_bot_in,
    input  logic             en_in,
    input  logic             dis,
    output logic [WIDTH-1:0] top_word,
    output logic [WIDTH-1:0] bot_word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH);

    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             lane_clear, lane_load;
    logic             stop_ok, stop_bad;
    logic             last_bit;

    logic [WIDTH-1:0] top_shift, bot_shift;
    logic [WIDTH-1:0] top_word_reg, bot_word_reg;
    logic             word_valid_reg, frame_err_reg, overrun_reg;
    logic             accept;

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // dis outranks both start detection and the stop check.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lane_clear = 1'b0;
        lane_load  = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        if (en_in) begin
            case (state_reg)
                IDLE: begin
                    if (!dis && data_top_in == START_LVL) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        lane_clear = 1'b1;
                    end
                end
                DATA: begin
                    if (dis) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        lane_load = 1'b1;
                        if (last_bit) begin
                            state_next = STOP;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (!dis) begin
                        stop_ok  = (data_top_in == STOP_LVL);
                        stop_bad = (data_top_in != STOP_LVL);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    lane_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_top_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (lane_clear),
        .load   (lane_load),
        .idx    (cnt_reg),
        .bit_in (data_top_in),
        .word   (top_shift)
    );

    lane_deser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bot_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (lane_clear),
        .load   (lane_load),
        .idx    (cnt_reg),
        .bit_in (data_bot_in),
        .word   (bot_shift)
    );

    assign accept = word_valid_reg & word_ready;

    // A completion may refill the buffer in the same cycle the old word leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_word_reg   <= '0;
            bot_word_reg   <= '0;
            word_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            frame_err_reg <= stop_bad;
            if (stop_ok && (!word_valid_reg || word_ready)) begin
                top_word_reg   <= top_shift;
                bot_word_reg   <= bot_shift;
                word_valid_reg <= 1'b1;
            end else if (accept) begin
                word_valid_reg <= 1'b0;
            end
            if (stop_ok && word_valid_reg && !word_ready) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign top_word   = top_word_reg;
    assign bot_word   = bot_word_reg;
    assign word_valid = word_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_receive_pair.sv
// Directed bench for receive_pair (WIDTH=8): framing, errors, overrun, enable gaps,
// abort and asynchronous reset.
module tb_receive_pair;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_top_in;
    logic       data_bot_in;
    logic       en_in;
    logic       dis;
    logic [7:0] top_word;
    logic [7:0] bot_word;
    logic       word_valid;
    logic       word_ready;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    receive_pair #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_top_in (data_top_in),
        .data_bot_in (data_bot_in),
        .en_in       (en_in),
        .dis         (dis),
        .top_word    (top_word),
        .bot_word    (bot_word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic t, input logic b, input logic en, input logic d);
        data_top_in = t;
        data_bot_in = b;
        en_in       = en;
        dis         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] t, input logic [7:0] b,
                              input logic stop_bit, input bit gap);
        if (gap) drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (gap) drive(~t[i], ~b[i], 1'b0, 1'b0);
            drive(t[i], b[i], 1'b1, 1'b0);
        end
        if (gap) drive(~stop_bit, 1'b1, 1'b0, 1'b0);
        drive(stop_bit, 1'b1, 1'b1, 1'b0);
        $display("frame top=%02h bot=%02h stop=%0b gap=%0b -> valid=%0b top_word=%02h bot_word=%02h ferr=%0b ovr=%0b",
                 t, b, stop_bit, gap, word_valid, top_word, bot_word, frame_err, overrun);
    endtask

    task automatic test_reset;
        reset = 1'b0; data_top_in = 1'b0; data_bot_in = 1'b0;
        en_in = 1'b0; dis = 1'b0; word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({top_word, bot_word, word_valid, frame_err, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got top=%h bot=%h v=%b fe=%b ov=%b, expected all 0",
                     top_word, bot_word, word_valid, frame_err, overrun);
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_basic;
        word_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive(8'hA5 >> i, 8'h3C >> i, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b expected 0", word_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        $display("basic frame A5/3C: valid=%0b top=%02h bot=%02h", word_valid, top_word, bot_word);
        checks++;
        if (word_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %b expected 1", word_valid);
        end
        checks++;
        if (top_word !== 8'hA5) begin
            errors++; $display("FAIL basic_top: got %h expected a5", top_word);
        end
        checks++;
        if (bot_word !== 8'h3C) begin
            errors++; $display("FAIL basic_bot: got %h expected 3c", bot_word);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle: got %b expected 0", word_valid);
        end
    endtask

    task automatic test_frame_err;
        word_ready = 1'b1;
        send_frame(8'hA5, 8'h3C, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++; $display("FAIL ferr_pulse: got %b expected 1", frame_err);
        end
        checks++;
        if (word_valid !== 1'b0) begin
            errors++; $display("FAIL ferr_no_valid: got %b expected 0", word_valid);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL ferr_single: got %b expected 0", frame_err);
        end
        send_frame(8'h3E, 8'h71, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || top_word !== 8'h3E || bot_word !== 8'h71) begin
            errors++;
            $display("FAIL ferr_recover: got v=%b top=%h bot=%h expected v=1 top=3e bot=71",
                     word_valid, top_word, bot_word);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun;
        word_ready = 1'b0;
        send_frame(8'h11, 8'h01, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || top_word !== 8'h11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got v=%b top=%h ov=%b expected v=1 top=11 ov=0",
                     word_valid, top_word, overrun);
        end
        send_frame(8'h22, 8'h02, 1'b0, 1'b0);
        checks++;
        if (top_word !== 8'h11 || bot_word !== 8'h01) begin
            errors++;
            $display("FAIL ovr_hold: got top=%h bot=%h expected top=11 bot=01", top_word, bot_word);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_flag: got %b expected 1", overrun);
        end
        word_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (word_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept: got v=%b ov=%b expected v=0 ov=1", word_valid, overrun);
        end
    endtask

    task automatic test_enable_gaps;
        word_ready = 1'b1;
        send_frame(8'h5A, 8'hC7, 1'b0, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || top_word !== 8'h5A || bot_word !== 8'hC7) begin
            errors++;
            $display("FAIL gap_word: got v=%b top=%h bot=%h expected v=1 top=5a bot=c7",
                     word_valid, top_word, bot_word);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        logic seen_valid = 1'b0;
        logic seen_ferr  = 1'b0;
        word_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            seen_valid |= word_valid;
            seen_ferr  |= frame_err;
        end
        $display("abort after 4 bits: valid_seen=%0b ferr_seen=%0b", seen_valid, seen_ferr);
        checks++;
        if (seen_valid !== 1'b0 || seen_ferr !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got valid_seen=%b ferr_seen=%b expected 0 0",
                     seen_valid, seen_ferr);
        end
        send_frame(8'hC3, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || top_word !== 8'hC3 || bot_word !== 8'h3C || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: got v=%b top=%h bot=%h fe=%b expected v=1 top=c3 bot=3c fe=0",
                     word_valid, top_word, bot_word, frame_err);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        logic seen_valid = 1'b0;
        word_ready = 1'b0;
        send_frame(8'h11, 8'h01, 1'b0, 1'b0);
        send_frame(8'h22, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        $display("async reset mid-frame: v=%0b top=%02h bot=%02h ov=%0b", word_valid, top_word, bot_word, overrun);
        checks++;
        if ({top_word, bot_word, word_valid, frame_err, overrun} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got top=%h bot=%h v=%b fe=%b ov=%b expected all 0",
                     top_word, bot_word, word_valid, frame_err, overrun);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        word_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            seen_valid |= word_valid;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got valid_seen=%b expected 0", seen_valid);
        end
        send_frame(8'h96, 8'h4B, 1'b0, 1'b0);
        checks++;
        if (word_valid !== 1'b1 || top_word !== 8'h96 || bot_word !== 8'h4B || overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: got v=%b top=%h bot=%h ov=%b expected v=1 top=96 bot=4b ov=0",
                     word_valid, top_word, bot_word, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_enable_gaps();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
